// File: rtl/hacd_pkg.sv
// Shared register-bus types for the HACD register space.
package hacd_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_intf_resp_d32;

endpackage

// File: rtl/hacd_reg_initiator_if.sv
// Command, reg-bus and completion signals of the HACD register initiator.
interface hacd_reg_initiator_if;

    logic                          cmd_valid_i;
    logic                          cmd_ready_o;
    logic                          cmd_write_i;
    logic [31:0]                   cmd_addr_i;
    logic [31:0]                   cmd_wdata_i;
    logic [3:0]                    cmd_wstrb_i;
    hacd_pkg::reg_intf_req_a32_d32 req_o;
    hacd_pkg::reg_intf_resp_d32    resp_i;
    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [31:0]                   rsp_rdata_o;
    logic                          rsp_error_o;
    logic                          rsp_timeout_o;
    logic                          busy_o;

    // slave: the initiator itself; master: sequencer plus responder side
    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        input  resp_i, rsp_ready_i,
        output cmd_ready_o, req_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
        output rsp_timeout_o, busy_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
        output resp_i, rsp_ready_i,
        input  cmd_ready_o, req_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
        input  rsp_timeout_o, busy_o
    );

endinterface

// File: rtl/hacd_reg_initiator.sv
// Register-bus initiator: queues sequencer commands and issues them one at a
// time on the HACD reg bus, returning each completion with error/timeout flags.
module hacd_reg_initiator #(
    parameter int unsigned CMD_DEPTH = 2,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    hacd_reg_initiator_if.slave  bus
);

    localparam int unsigned AW      = $clog2(CMD_DEPTH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    cmd_t                          mem [CMD_DEPTH];
    cmd_t                          head;
    logic [AW-1:0]                 wr_ptr, rd_ptr;
    logic [AW:0]                   cnt, cnt_nxt;
    logic [1:0]                    state, state_nxt;
    logic                          push, pop, timeout_hit;
    logic                          cmd_rdy_q, busy_q;
    logic [15:0]                   tcnt;
    hacd_pkg::reg_intf_req_a32_d32 req_q;
    logic                          rsp_valid_q, rsp_error_q, rsp_timeout_q;
    logic [31:0]                   rsp_rdata_q;

    assign head        = mem[rd_ptr];
    assign push        = bus.cmd_valid_i && cmd_rdy_q;
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TO_LAST) && !bus.resp_i.ready;

    always_comb begin
        pop       = 1'b0;
        state_nxt = state;
        case (state)
            IDLE:  if (cnt != '0) begin
                       pop       = 1'b1;
                       state_nxt = ISSUE;
                   end
            ISSUE: if (bus.resp_i.ready || timeout_hit) state_nxt = RESP;
            RESP:  if (bus.rsp_ready_i) begin
                       if (cnt != '0) begin
                           pop       = 1'b1;
                           state_nxt = ISSUE;
                       end else begin
                           state_nxt = IDLE;
                       end
                   end
            default: state_nxt = IDLE;
        endcase
        cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{write: bus.cmd_write_i, addr: bus.cmd_addr_i,
                                   wdata: bus.cmd_wdata_i, wstrb: bus.cmd_wstrb_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            cmd_rdy_q     <= 1'b0;
            busy_q        <= 1'b0;
            tcnt          <= '0;
            req_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_rdy_q <= (cnt_nxt != (AW+1)'(CMD_DEPTH));
            busy_q    <= (cnt_nxt != '0) || (state_nxt != IDLE);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            if (pop) begin
                // reads never drive write data or strobes onto the bus
                req_q <= '{valid: 1'b1, write: head.write, addr: head.addr,
                           wdata: head.write ? head.wdata : '0,
                           wstrb: head.write ? head.wstrb : '0};
                tcnt  <= '0;
            end else if (state == ISSUE && state_nxt == RESP) begin
                req_q       <= '0;
                rsp_valid_q <= 1'b1;
                if (bus.resp_i.ready) begin
                    rsp_rdata_q   <= req_q.write ? '0 : bus.resp_i.rdata;
                    rsp_error_q   <= bus.resp_i.error;
                    rsp_timeout_q <= 1'b0;
                end else begin
                    rsp_rdata_q   <= '0;
                    rsp_error_q   <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                end
            end else if (state == ISSUE) begin
                tcnt <= tcnt + 16'd1;
            end

            if (state == RESP && bus.rsp_ready_i) begin
                rsp_valid_q   <= 1'b0;
                rsp_rdata_q   <= '0;
                rsp_error_q   <= 1'b0;
                rsp_timeout_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready_o   = cmd_rdy_q;
    assign bus.busy_o        = busy_q;
    assign bus.req_o         = req_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.rsp_error_o   = rsp_error_q;
    assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_hacd_reg_initiator.sv
// Directed bench for hacd_reg_initiator (CMD_DEPTH=2, TIMEOUT=4).
module tb_hacd_reg_initiator;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rlog_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } qlog_t;

    logic clk_i, rst_ni;
    hacd_reg_initiator_if bus ();

    logic [7:0]  icnt, r_wait;
    logic        r_err;
    logic [31:0] r_rdata;
    int          n_tests, n_fail;
    rlog_t       rsp_log[$];
    qlog_t       req_log[$];

    hacd_reg_initiator #(.CMD_DEPTH(2), .TIMEOUT(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Responder model: ready after r_wait stall cycles (255 = never); rdata is addr ^ r_rdata.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) icnt <= '0;
        else         icnt <= (bus.req_o.valid && !bus.resp_i.ready) ? icnt + 8'd1 : 8'd0;
    end
    assign bus.resp_i.ready = bus.req_o.valid && (icnt == r_wait);
    assign bus.resp_i.rdata = bus.req_o.addr ^ r_rdata;
    assign bus.resp_i.error = r_err;

    always @(posedge clk_i) begin
        if (bus.rsp_valid_o && bus.rsp_ready_i)
            rsp_log.push_back('{rdata: bus.rsp_rdata_o, err: bus.rsp_error_o, to: bus.rsp_timeout_o});
        if (bus.req_o.valid && bus.resp_i.ready)
            req_log.push_back('{write: bus.req_o.write, addr: bus.req_o.addr, wdata: bus.req_o.wdata});
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit done = 1'b0;
        @(negedge clk_i);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        bus.cmd_wstrb_i = s;
        for (int i = 0; i < 60 && !done; i++) begin
            if (bus.cmd_ready_o) begin
                @(posedge clk_i);
                done = 1'b1;
            end else begin
                @(negedge clk_i);
            end
        end
        #1 bus.cmd_valid_i = 1'b0;
        if (!done) chk("push_bound", 0, 1);
    endtask

    // Counts req_o.valid cycles until rsp_valid_o, checking fields stay stable.
    task automatic wait_rsp(output int nv, output logic stab,
                            output hacd_pkg::reg_intf_req_a32_d32 first);
        nv = 0; stab = 1'b1; first = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o) break;
            if (bus.req_o.valid) begin
                if (nv == 0) first = bus.req_o;
                else if (bus.req_o !== first) stab = 1'b0;
                nv++;
            end
        end
        if (!bus.rsp_valid_o) chk("rsp_bound", 0, 1);
    endtask

    initial begin
        int                            nv, base_q, base_r, seen, nrsp;
        logic                          stab;
        hacd_pkg::reg_intf_req_a32_d32 first, exp_req;
        logic [31:0]                   a_k [4];
        logic                          w_k [4];

        n_tests = 0; n_fail = 0;
        rst_ni = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
        bus.cmd_wdata_i = '0;   bus.cmd_wstrb_i = '0;   bus.rsp_ready_i = 1'b1;
        r_wait = 8'd0; r_err = 1'b0; r_rdata = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_cmd_ready", bus.cmd_ready_o, 0);
        chk("rst_req", bus.req_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_cmd_ready", bus.cmd_ready_o, 1);

        // single write, zero-wait responder; write completion carries rdata 0
        r_rdata = 32'hFFFF_FFFF;
        push_cmd(1'b1, 32'h4, 32'h10, 4'hF);
        @(negedge clk_i);
        chk("wr_req_n1", bus.req_o.valid, 0);
        chk("wr_busy", bus.busy_o, 1);
        @(negedge clk_i);
        exp_req = '{valid: 1'b1, write: 1'b1, addr: 32'h4, wdata: 32'h10, wstrb: 4'hF};
        chk("wr_req_n2", bus.req_o, exp_req);
        @(negedge clk_i);
        chk("wr_req_drop", bus.req_o.valid, 0);
        chk("wr_rsp_valid", bus.rsp_valid_o, 1);
        chk("wr_rsp_fields", {bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o}, 0);
        @(negedge clk_i);
        chk("wr_rsp_done", bus.rsp_valid_o, 0);
        chk("wr_idle_busy", bus.busy_o, 0);

        // read with 3 wait cycles: 0x0 ^ 0x3 = 0x3
        r_wait = 8'd3; r_rdata = 32'h3;
        push_cmd(1'b0, 32'h0, 32'hAAAA, 4'hF);
        wait_rsp(nv, stab, first);
        chk("rd_valid_cycles", nv, 4);
        chk("rd_stable", stab, 1);
        exp_req = '{valid: 1'b1, write: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
        chk("rd_req_fields", first, exp_req);
        chk("rd_rsp", {bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o}, {32'h3, 2'b00});
        @(negedge clk_i);

        // responder error: 0x8 ^ 0x8 = 0
        r_wait = 8'd0; r_err = 1'b1; r_rdata = 32'h8;
        push_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        wait_rsp(nv, stab, first);
        chk("err_rsp", {bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o}, {32'h0, 2'b10});
        @(negedge clk_i);
        r_err = 1'b0;

        // timeout: ready never rises
        r_wait = 8'd255; r_rdata = 32'h55;
        push_cmd(1'b0, 32'hC, 32'h0, 4'h0);
        wait_rsp(nv, stab, first);
        chk("to_valid_cycles", nv, 4);
        chk("to_rsp", {bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o}, {32'h0, 2'b11});
        @(negedge clk_i);

        // ready in the 4th ISSUE cycle still succeeds: 0x10 ^ 0x77 = 0x67
        r_wait = 8'd3; r_rdata = 32'h77;
        push_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(nv, stab, first);
        chk("to_edge_cycles", nv, 4);
        chk("to_edge_rsp", {bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o}, {32'h67, 2'b00});
        @(negedge clk_i);

        // backpressure: 1 in flight + 2 queued, 4th waits for the release
        r_wait = 8'd0; r_rdata = 32'h5A00_0000; bus.rsp_ready_i = 1'b0;
        base_q = req_log.size(); base_r = rsp_log.size();
        for (int k = 0; k < 4; k++) begin
            a_k[k] = 32'h100 + 32'(4 * k);
            w_k[k] = (k % 2 == 0);
        end
        for (int k = 0; k < 3; k++) push_cmd(w_k[k], a_k[k], 32'hA0 + 32'(k), 4'hF);
        @(negedge clk_i);
        chk("bp_full", bus.cmd_ready_o, 0);
        chk("bp_rsp_held", bus.rsp_valid_o, 1);
        fork
            push_cmd(w_k[3], a_k[3], 32'hA3, 4'hF);
            begin
                repeat (3) @(negedge clk_i);
                chk("bp_still_full", bus.cmd_ready_o, 0);
                bus.rsp_ready_i = 1'b1;
            end
        join
        for (int i = 0; i < 100 && rsp_log.size() < base_r + 4; i++) @(negedge clk_i);
        chk("bp_rsp_count", rsp_log.size() - base_r, 4);
        chk("bp_req_count", req_log.size() - base_q, 4);
        for (int k = 0; k < 4; k++) begin
            if (rsp_log.size() >= base_r + 4 && req_log.size() >= base_q + 4) begin
                chk($sformatf("bp_req%0d", k), req_log[base_q + k],
                    {w_k[k], a_k[k], w_k[k] ? 32'hA0 + 32'(k) : 32'h0});
                chk($sformatf("bp_rsp%0d", k), rsp_log[base_r + k],
                    {w_k[k] ? 32'h0 : (a_k[k] ^ 32'h5A00_0000), 2'b00});
            end
        end
        @(negedge clk_i);
        chk("bp_idle", bus.busy_o, 0);

        // reset during ISSUE with one command queued
        r_wait = 8'd255;
        push_cmd(1'b0, 32'h200, 32'h0, 4'h0);
        push_cmd(1'b1, 32'h204, 32'hBEEF, 4'hF);
        @(negedge clk_i);
        chk("mr_issue", bus.req_o.valid, 1);
        chk("mr_queued", bus.busy_o, 1);
        nrsp = rsp_log.size();
        #2 rst_ni = 1'b0;
        #1;
        chk("mr_req_zero", bus.req_o, 0);
        chk("mr_rsp_zero", {bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_error_o, bus.rsp_timeout_o}, 0);
        chk("mr_busy", bus.busy_o, 0);
        chk("mr_cmd_ready", bus.cmd_ready_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o || bus.req_o.valid) seen++;
        end
        chk("mr_no_activity", seen, 0);
        chk("mr_no_rsp", rsp_log.size(), nrsp);
        chk("mr_busy_after", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hacd_reg_initiator.md
# hacd_reg_initiator

Register-bus initiator for the HACD register space. It accepts 32-bit read/write commands from a local sequencer (boot programmer or debug bridge) into a small command FIFO. It drives them one at a time onto a `hacd_pkg::reg_intf_req_a32_d32` request port, and returns each completion (read data, error, timeout) on a valid/ready response port. It sits upstream of the HACD register responder and talks to it over the same reg-bus types.

## Interface
- `CMD_DEPTH`, 2, command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 256, max cycles to wait for `resp_i.ready` per transaction; 0 disables; ≤65535.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  32  register byte address.
- `cmd_wdata_i`  in  32  write data.
- `cmd_wstrb_i`  in  4  write byte strobes.
- `req_o`  out  `hacd_pkg::reg_intf_req_a32_d32`  reg-bus request: valid, write, addr, wdata, wstrb.
- `resp_i`  in  `hacd_pkg::reg_intf_resp_d32`  reg-bus response: ready, rdata, error.
- `rsp_valid_o`  out  1  completion valid.
- `rsp_ready_i`  in  1  completion consumed.
- `rsp_rdata_o`  out  32  read data; 0 for writes and timeouts.
- `rsp_error_o`  out  1  responder error or timeout.
- `rsp_timeout_o`  out  1  transaction timed out.
- `busy_o`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- **Command FIFO**
  - `cmd_ready_o = !full`, registered-count based; a same-cycle pop does not raise it.
  - Push and pop in the same cycle are legal whenever the FIFO is non-empty.
  - The pointers wrap modulo `CMD_DEPTH`.
- **FSM states:** IDLE, ISSUE, RESP.
  - IDLE → ISSUE when the FIFO is non-empty. The head is popped and loaded into the request registers.
  - ISSUE: `req_o.valid=1`; all request fields are held stable.
    - On a cycle with `resp_i.ready=1`, capture `resp_i.rdata` (reads only; 0 for writes) and `resp_i.error`, then → RESP.
    - If `TIMEOUT≠0` and ready has not been seen in `TIMEOUT` ISSUE cycles, → RESP with `rsp_error_o=1`, `rsp_timeout_o=1`, `rsp_rdata_o=0`.
  - RESP: `rsp_valid_o=1`, fields held until `rsp_ready_i`.
    - On handshake, → ISSUE if the FIFO is non-empty (pop), else → IDLE.
- **Request fields**
  - For reads, `req_o.wdata=0` and `req_o.wstrb=0`.
  - Outside ISSUE, `req_o` is all-zero.
- **Timeout counter**
  - 16 bits; cleared on entry to ISSUE; increments each ISSUE cycle with ready low.
  - Timeout fires when the count reaches `TIMEOUT-1` with ready still low.
  - A ready in the `TIMEOUT`-th cycle is a success.
  - `resp_i` arriving after the timeout is ignored.
- **One outstanding transaction.** No new request is issued until the response is consumed.
- **Reset values (async, any time, including mid-transaction):**
  - FIFO is flushed and the FSM goes to IDLE.
  - `req_o`=0, `rsp_*`=0, `busy_o`=0.
  - `cmd_ready_o`=0 while `rst_ni` is low, 1 from the first cycle after deassertion.
  - An aborted transaction produces no response.

## Timing
- **Command to request:** command accepted at edge N → FIFO non-empty at N+1 → `req_o.valid` high at N+2.
- **Zero-wait responder:** `req_o.valid` for exactly 1 cycle (M); `rsp_valid_o` high at M+1.
- **Back-to-back:** a response consumed at cycle R with the FIFO non-empty gives the next `req_o.valid` at R+1. Minimum issue spacing is 2 cycles.
- **Timeout:** ISSUE entered at cycle S, ready never high → `req_o.valid` low and `rsp_valid_o` high at S+`TIMEOUT`.
- All outputs are registered except `cmd_ready_o`, which is a registered-flag decode. There are no combinational paths from `resp_i` or `rsp_ready_i` to any output.

## Test plan
- **Single write:** `cmd` write addr 0x4, wdata 0x0000_0010, wstrb 0xF; responder ready tied 1.
  - `req_o` {valid=1, write=1, addr=0x4, wdata=0x10} for 1 cycle at N+2.
  - Response {rdata=0, error=0, timeout=0} at N+3.
- **Read:** read addr 0x0; responder returns rdata 0x0000_0003 after 3 wait cycles.
  - `req_o.valid` high for 4 cycles with stable fields; `rsp_rdata_o=0x3`, error 0.
- **Responder error:** read addr 0x8; responder returns error=1 → `rsp_error_o=1`, `rsp_timeout_o=0`, `rdata=0`.
- **Timeout (`TIMEOUT=4`):** ready held low → `req_o.valid` high exactly 4 cycles; response error=1, timeout=1.
  - Repeat with ready high on the 4th cycle → success.
- **Backpressure:** `CMD_DEPTH=2`; push 4 commands while `rsp_ready_i=0`.
  - `cmd_ready_o` drops after 2 queued plus 1 in flight.
  - Release → all 4 complete in order, with addresses and data matching.
- **Reset mid-transaction:** assert `rst_ni` low during ISSUE with 1 queued command.
  - Outputs go to 0 immediately; after release, no response and `busy_o=0`.
